// File: rtl/toggle_check_8b_if.sv
// Pattern-checker bus: mode/sample inputs from the source side and status/log outputs
// from the checker. The parameter CNT_W must match the checker instance it connects to.
interface toggle_check_8b_if #(parameter int CNT_W = 8);
  logic [1:0]       en;
  logic [7:0]       data_in;
  logic             valid;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
  logic [7:0]       fail_data;
  logic [7:0]       fail_mask;

  modport master (
    output en, data_in, valid,
    input  locked, err, err_cnt, fail_data, fail_mask
  );

  modport slave (
    input  en, data_in, valid,
    output locked, err, err_cnt, fail_data, fail_mask
  );
endinterface

// File: rtl/toggle_check_8b.sv
// Alternating-pattern checker (P, ~P) with phase lock, flywheel and saturating error count.
// Optional first-failure log enabled by defining TOGGLE_CHECK_FAIL_LOG_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | en == 00, checker off, samples ignored, counters held
// ST_SYNC  | hunting for a legal sample (P or ~P) to pick up the phase
// ST_CHECK | locked, each sample compared against the expected phase
module toggle_check_8b #(
  parameter int CNT_W  = 8,
  parameter int LOSS_N = 2
) (
  input  logic             clk,
  input  logic             rst,
  toggle_check_8b_if.slave bus
);
  localparam int RUN_W = (LOSS_N < 2) ? 1 : $clog2(LOSS_N + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOSS_N - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_CHECK} state_t;

  state_t           r_state;
  logic [1:0]       r_en_q;
  logic             r_locked;
  logic             r_err;
  logic [CNT_W-1:0] r_err_cnt;
  logic [7:0]       r_expected;
  logic [RUN_W-1:0] r_run;

  logic [7:0] w_pat;
  logic       w_legal;
  logic       w_en_off;
  logic       w_start;
  logic       w_en_chg;
  logic       w_sample;
  logic       w_mis;

  always_comb begin
    w_pat = 8'h00;
    case (bus.en)
      2'b01:   w_pat = 8'h55;
      2'b10:   w_pat = 8'h00;
      2'b11:   w_pat = 8'h33;
      default: w_pat = 8'h00;
    endcase
  end

  assign w_legal  = (bus.data_in == w_pat) || (bus.data_in == ~w_pat);
  assign w_en_off = (bus.en == 2'b00);
  assign w_start  = !w_en_off && (r_state == ST_IDLE);
  // A mode change between nonzero values wins over a sample arriving in the same cycle.
  assign w_en_chg = !w_en_off && (r_state != ST_IDLE) && (bus.en != r_en_q);
  assign w_sample = !w_en_off && !w_start && !w_en_chg && bus.valid;
  assign w_mis    = w_sample &&
                    (((r_state == ST_SYNC) && !w_legal) ||
                     ((r_state == ST_CHECK) && (bus.data_in != r_expected)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_en_q     <= 2'b00;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
      r_err_cnt  <= '0;
      r_expected <= 8'h00;
      r_run      <= '0;
    end else begin
      r_en_q <= bus.en;
      r_err  <= w_mis;
      if (w_mis && (r_err_cnt != {CNT_W{1'b1}}))
        r_err_cnt <= r_err_cnt + 1'b1;

      if (w_en_off) begin
        r_state  <= ST_IDLE;
        r_locked <= 1'b0;
      end else if (w_start) begin
        r_state   <= ST_SYNC;
        r_locked  <= 1'b0;
        r_err_cnt <= '0;
        r_run     <= '0;
      end else if (w_en_chg) begin
        r_state  <= ST_SYNC;
        r_locked <= 1'b0;
        r_run    <= '0;
      end else if (bus.valid) begin
        case (r_state)
          ST_SYNC: begin
            if (w_legal) begin
              r_state    <= ST_CHECK;
              r_expected <= ~bus.data_in;
              r_locked   <= 1'b1;
              r_run      <= '0;
            end
          end
          ST_CHECK: begin
            // Flywheel: the expected phase advances on every sample, good or bad.
            r_expected <= ~r_expected;
            if (bus.data_in == r_expected) begin
              r_run <= '0;
            end else if (r_run == RUN_LAST) begin
              r_state  <= ST_SYNC;
              r_locked <= 1'b0;
              r_run    <= '0;
            end else begin
              r_run <= r_run + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.locked  = r_locked;
  assign bus.err     = r_err;
  assign bus.err_cnt = r_err_cnt;

`ifdef TOGGLE_CHECK_FAIL_LOG_EN
  logic       r_fail_seen;
  logic [7:0] r_fail_data;
  logic [7:0] r_fail_mask;
  logic [7:0] w_mask;

  // In SYNC there is no phase yet, so the mask is taken against the base pattern.
  assign w_mask = (r_state == ST_SYNC) ? (bus.data_in ^ w_pat) : (bus.data_in ^ r_expected);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fail_seen <= 1'b0;
      r_fail_data <= 8'h00;
      r_fail_mask <= 8'h00;
    end else if (w_start) begin
      r_fail_seen <= 1'b0;
      r_fail_data <= 8'h00;
      r_fail_mask <= 8'h00;
    end else if (w_mis && !r_fail_seen) begin
      r_fail_seen <= 1'b1;
      r_fail_data <= bus.data_in;
      r_fail_mask <= w_mask;
    end
  end

  assign bus.fail_data = r_fail_data;
  assign bus.fail_mask = r_fail_mask;
`else
  assign bus.fail_data = 8'h00;
  assign bus.fail_mask = 8'h00;
`endif
endmodule

// File: tb/tb_toggle_check_8b.sv
// Table-driven bench for toggle_check_8b: a default instance and a CNT_W=2 instance share
// the same stimulus; expected results go through a scoreboard queue and are checked after each edge.
module tb_toggle_check_8b;
  logic clk;
  logic rst;

  toggle_check_8b_if #(.CNT_W(8)) bus ();
  toggle_check_8b_if #(.CNT_W(2)) bus2 ();

  toggle_check_8b #(.CNT_W(8), .LOSS_N(2)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  toggle_check_8b #(.CNT_W(2), .LOSS_N(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  assign bus2.en      = bus.en;
  assign bus2.valid   = bus.valid;
  assign bus2.data_in = bus.data_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] en;
    logic       v;
    logic [7:0] d;
    logic       lk;
    logic       er;
    logic [7:0] cnt;
    logic [7:0] fd;
    logic [7:0] fm;
  } vec_t;

  vec_t tbl [32];
  vec_t sb [$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   err2_pulses = 0;

  function automatic vec_t mk(input logic r, input logic [1:0] e, input logic v,
                              input logic [7:0] d, input logic lk, input logic er,
                              input logic [7:0] cnt, input logic [7:0] fd, input logic [7:0] fm);
    vec_t t;
    t.rst = r; t.en = e; t.v = v; t.d = d;
    t.lk = lk; t.er = er; t.cnt = cnt; t.fd = fd; t.fm = fm;
    return t;
  endfunction

  function automatic logic [7:0] fl(input logic [7:0] x);
`ifdef TOGGLE_CHECK_FAIL_LOG_EN
    return x;
`else
    return x & 8'h00;
`endif
  endfunction

  function automatic logic [7:0] sat3(input logic [7:0] x);
    return (x > 8'd3) ? 8'd3 : x;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
  endtask

  task automatic apply(input vec_t t, input int idx);
    vec_t e;
    @(negedge clk);
    rst         = t.rst;
    bus.en      = t.en;
    bus.valid   = t.v;
    bus.data_in = t.d;
    sb.push_back(t);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (bus2.err) err2_pulses++;
    chk("locked",     idx, {7'd0, bus.locked},  {7'd0, e.lk});
    chk("err",        idx, {7'd0, bus.err},     {7'd0, e.er});
    chk("err_cnt",    idx, bus.err_cnt,         e.cnt);
    chk("fail_data",  idx, bus.fail_data,       fl(e.fd));
    chk("fail_mask",  idx, bus.fail_mask,       fl(e.fm));
    chk("locked_w2",  idx, {7'd0, bus2.locked}, {7'd0, e.lk});
    chk("err_w2",     idx, {7'd0, bus2.err},    {7'd0, e.er});
    chk("err_cnt_w2", idx, {6'd0, bus2.err_cnt}, sat3(e.cnt));
  endtask

  initial begin
    rst = 1'b1; bus.en = 2'b00; bus.valid = 1'b0; bus.data_in = 8'h00;

    //            rst en     v  data   lk er cnt   fd     fm
    tbl[0]  = mk(1, 2'b00, 0, 8'h00, 0, 0, 8'd0, 8'h00, 8'h00);
    tbl[1]  = mk(1, 2'b00, 0, 8'h00, 0, 0, 8'd0, 8'h00, 8'h00);
    tbl[2]  = mk(0, 2'b01, 0, 8'h00, 0, 0, 8'd0, 8'h00, 8'h00);
    tbl[3]  = mk(0, 2'b01, 1, 8'h55, 1, 0, 8'd0, 8'h00, 8'h00);
    tbl[4]  = mk(0, 2'b01, 1, 8'hAA, 1, 0, 8'd0, 8'h00, 8'h00);
    tbl[5]  = mk(0, 2'b01, 1, 8'h55, 1, 0, 8'd0, 8'h00, 8'h00);
    tbl[6]  = mk(0, 2'b01, 1, 8'hAA, 1, 0, 8'd0, 8'h00, 8'h00);
    tbl[7]  = mk(0, 2'b00, 1, 8'h12, 0, 0, 8'd0, 8'h00, 8'h00);
    tbl[8]  = mk(0, 2'b10, 0, 8'h00, 0, 0, 8'd0, 8'h00, 8'h00);
    tbl[9]  = mk(0, 2'b10, 1, 8'h00, 1, 0, 8'd0, 8'h00, 8'h00);
    tbl[10] = mk(0, 2'b10, 1, 8'hFF, 1, 0, 8'd0, 8'h00, 8'h00);
    tbl[11] = mk(0, 2'b10, 1, 8'h00, 1, 0, 8'd0, 8'h00, 8'h00);
    tbl[12] = mk(0, 2'b10, 1, 8'hFE, 1, 1, 8'd1, 8'hFE, 8'h01);
    tbl[13] = mk(0, 2'b10, 1, 8'h00, 1, 0, 8'd1, 8'hFE, 8'h01);
    tbl[14] = mk(0, 2'b11, 1, 8'h33, 0, 0, 8'd1, 8'hFE, 8'h01);
    tbl[15] = mk(0, 2'b11, 1, 8'h33, 1, 0, 8'd1, 8'hFE, 8'h01);
    tbl[16] = mk(0, 2'b11, 1, 8'hCC, 1, 0, 8'd1, 8'hFE, 8'h01);
    tbl[17] = mk(0, 2'b11, 1, 8'h12, 1, 1, 8'd2, 8'hFE, 8'h01);
    tbl[18] = mk(0, 2'b11, 1, 8'h12, 0, 1, 8'd3, 8'hFE, 8'h01);
    tbl[19] = mk(0, 2'b11, 1, 8'hCC, 1, 0, 8'd3, 8'hFE, 8'h01);
    tbl[20] = mk(0, 2'b11, 1, 8'h33, 1, 0, 8'd3, 8'hFE, 8'h01);
    tbl[21] = mk(0, 2'b11, 0, 8'h12, 1, 0, 8'd3, 8'hFE, 8'h01);
    tbl[22] = mk(0, 2'b11, 1, 8'hCC, 1, 0, 8'd3, 8'hFE, 8'h01);
    tbl[23] = mk(1, 2'b11, 1, 8'h12, 0, 0, 8'd0, 8'h00, 8'h00);
    tbl[24] = mk(0, 2'b11, 0, 8'h00, 0, 0, 8'd0, 8'h00, 8'h00);
    tbl[25] = mk(0, 2'b11, 1, 8'hCC, 1, 0, 8'd0, 8'h00, 8'h00);
    tbl[26] = mk(0, 2'b01, 0, 8'h00, 0, 0, 8'd0, 8'h00, 8'h00);
    tbl[27] = mk(0, 2'b01, 1, 8'h12, 0, 1, 8'd1, 8'h12, 8'h47);
    tbl[28] = mk(0, 2'b01, 1, 8'h12, 0, 1, 8'd2, 8'h12, 8'h47);
    tbl[29] = mk(0, 2'b01, 1, 8'h12, 0, 1, 8'd3, 8'h12, 8'h47);
    tbl[30] = mk(0, 2'b01, 1, 8'h12, 0, 1, 8'd4, 8'h12, 8'h47);
    tbl[31] = mk(0, 2'b01, 1, 8'h12, 0, 1, 8'd5, 8'h12, 8'h47);

    for (int i = 0; i < 32; i++) apply(tbl[i], i);

    // Restart from IDLE in mode 10 and hit SYNC with five illegal samples:
    // the 2-bit counter must pin at 3 while err keeps pulsing.
    apply(mk(0, 2'b00, 0, 8'h00, 0, 0, 8'd5, 8'h12, 8'h47), 100);
    apply(mk(0, 2'b10, 0, 8'h00, 0, 0, 8'd0, 8'h00, 8'h00), 101);
    err2_pulses = 0;
    for (int k = 1; k <= 5; k++)
      apply(mk(0, 2'b10, 1, 8'h5A, 0, 1, 8'(k), 8'h5A, 8'h5A), 101 + k);
    apply(mk(0, 2'b10, 0, 8'h5A, 0, 0, 8'd5, 8'h5A, 8'h5A), 107);
    chk("err_pulses_w2", 108, 8'(err2_pulses), 8'd5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
